// File: rtl/ddr_burst_arbiter.sv
// Round-robin arbiter sharing one DDR controller burst port among three requesters,
// with per-burst beat-count checking and a hung-controller timeout.
module ddr_burst_arbiter #(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DDR_DATA_WIDTH = 128,
  parameter int LEN_WIDTH      = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        mem_clk,
  input  logic                        rst,
  input  logic [2:0]                  req_i,
  input  logic [2:0]                  req_wr_i,
  input  logic [3*DDR_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [3*LEN_WIDTH-1:0]      req_len_i,
  input  logic [3*DDR_DATA_WIDTH-1:0] req_wdata_i,
  output logic [2:0]                  gnt_o,
  output logic [2:0]                  done_o,
  output logic [2:0]                  err_o,
  output logic [2:0]                  rd_valid_o,
  output logic [2:0]                  wr_req_o,
  output logic [LEN_WIDTH-1:0]        beat_cnt_o,
  output logic                        rd_burst_req,
  output logic                        wr_burst_req,
  output logic [LEN_WIDTH-1:0]        rd_burst_len,
  output logic [LEN_WIDTH-1:0]        wr_burst_len,
  output logic [DDR_ADDR_WIDTH-1:0]   rd_burst_addr,
  output logic [DDR_ADDR_WIDTH-1:0]   wr_burst_addr,
  output logic [DDR_DATA_WIDTH-1:0]   wr_burst_data,
  input  logic                        rd_burst_data_valid,
  input  logic                        wr_burst_data_req,
  input  logic                        rd_burst_finish,
  input  logic                        wr_burst_finish
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [1:0]                last_q, last_d;
  logic [1:0]                sel_q, sel_d;
  logic [2:0]                gnt_q, gnt_d;
  logic                      wr_q, wr_d;
  logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [LEN_WIDTH-1:0]      beat_q, beat_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic                      tmo_err_q, tmo_err_d;

  logic       win_vld;
  logic [1:0] win;
  logic       in_burst, in_done, beat_inc, fin;

  // First asserted port at or after last_gnt+1 (mod 3) wins.
  always_comb begin
    int start;
    int c;
    win_vld = 1'b0;
    win     = 2'd0;
    start   = (last_q == 2'd2) ? 0 : int'(last_q) + 1;
    for (int i = 0; i < 3; i++) begin
      c = start + i;
      if (c >= 3) c = c - 3;
      if (!win_vld && req_i[c]) begin
        win_vld = 1'b1;
        win     = 2'(c);
      end
    end
  end

  assign in_burst = (state_q == S_BURST);
  assign in_done  = (state_q == S_DONE);
  assign beat_inc = in_burst && (wr_q ? wr_burst_data_req : rd_burst_data_valid);
  assign fin      = wr_q ? wr_burst_finish : rd_burst_finish;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    tmo_d     = tmo_q;
    tmo_err_d = tmo_err_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          sel_d     = win;
          gnt_d     = 3'b001 << win;
          wr_d      = req_wr_i[win];
          addr_d    = req_addr_i[int'(win)*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
          len_d     = req_len_i[int'(win)*LEN_WIDTH +: LEN_WIDTH];
          beat_d    = '0;
          tmo_d     = '0;
          tmo_err_d = 1'b0;
          state_d   = (req_len_i[int'(win)*LEN_WIDTH +: LEN_WIDTH] == '0) ? S_DONE : S_BURST;
        end
      end
      S_BURST: begin
        if (beat_inc && beat_q != '1) beat_d = beat_q + 1'b1;
        tmo_d = tmo_q + 1'b1;
        // A real finish takes priority over a timeout in the same cycle.
        if (fin) begin
          state_d = S_DONE;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_DONE;
          tmo_err_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        beat_d  = '0;
        last_d  = sel_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= 2'd2;
      sel_q     <= 2'd0;
      gnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign done_o        = in_done ? gnt_q : 3'b000;
  assign err_o         = (in_done && (tmo_err_q || beat_q != len_q)) ? gnt_q : 3'b000;
  assign rd_valid_o    = (in_burst && !wr_q && rd_burst_data_valid) ? gnt_q : 3'b000;
  assign wr_req_o      = (in_burst && wr_q && wr_burst_data_req) ? gnt_q : 3'b000;
  assign beat_cnt_o    = beat_q;
  assign rd_burst_req  = in_burst && !wr_q;
  assign wr_burst_req  = in_burst && wr_q;
  assign rd_burst_len  = len_q;
  assign wr_burst_len  = len_q;
  assign rd_burst_addr = addr_q;
  assign wr_burst_addr = addr_q;
  assign wr_burst_data = (state_q != S_IDLE) ?
                         req_wdata_i[int'(sel_q)*DDR_DATA_WIDTH +: DDR_DATA_WIDTH] : '0;
endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Directed bench for ddr_burst_arbiter; completions are checked by a scoreboard monitor.
module tb_ddr_burst_arbiter;
  localparam int AW = 28, DW = 128, LW = 10, TMO = 1024;

  logic            mem_clk, rst;
  logic [2:0]      req_i, req_wr_i;
  logic [3*AW-1:0] req_addr_i;
  logic [3*LW-1:0] req_len_i;
  logic [3*DW-1:0] req_wdata_i;
  logic [2:0]      gnt_o, done_o, err_o, rd_valid_o, wr_req_o;
  logic [LW-1:0]   beat_cnt_o, rd_burst_len, wr_burst_len;
  logic            rd_burst_req, wr_burst_req;
  logic [AW-1:0]   rd_burst_addr, wr_burst_addr;
  logic [DW-1:0]   wr_burst_data;
  logic            rd_burst_data_valid, wr_burst_data_req, rd_burst_finish, wr_burst_finish;

  ddr_burst_arbiter #(.DDR_ADDR_WIDTH(AW), .DDR_DATA_WIDTH(DW), .LEN_WIDTH(LW),
                      .TIMEOUT_CYCLES(TMO)) dut (
    .mem_clk(mem_clk), .rst(rst), .req_i(req_i), .req_wr_i(req_wr_i),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_wdata_i(req_wdata_i),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rd_valid_o(rd_valid_o),
    .wr_req_o(wr_req_o), .beat_cnt_o(beat_cnt_o), .rd_burst_req(rd_burst_req),
    .wr_burst_req(wr_burst_req), .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
    .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data(wr_burst_data), .rd_burst_data_valid(rd_burst_data_valid),
    .wr_burst_data_req(wr_burst_data_req), .rd_burst_finish(rd_burst_finish),
    .wr_burst_finish(wr_burst_finish));

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  typedef struct { int port; bit err; } exp_t;
  exp_t exp_q[$];
  int checks = 0, failures = 0;

  localparam logic [DW-1:0] WD2 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5A5A_A5A5;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic set_port(input int p, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    req_wr_i[p]           = wr;
    req_addr_i[p*AW +: AW] = a;
    req_len_i[p*LW +: LW]  = l;
  endtask

  // Issue nbeats strobes then a matching finish; returns in the DONE cycle.
  task automatic serve(input int port, input bit is_wr, input int nbeats);
    logic [2:0] own;
    own = 3'b001 << port;
    for (int i = 0; i < nbeats; i++) begin
      if (is_wr) wr_burst_data_req = 1'b1; else rd_burst_data_valid = 1'b1;
      #1;
      check("strobe_route", is_wr ? wr_req_o : rd_valid_o, own);
      tick();
      wr_burst_data_req = 1'b0;
      rd_burst_data_valid = 1'b0;
    end
    if (is_wr) wr_burst_finish = 1'b1; else rd_burst_finish = 1'b1;
    tick();
    wr_burst_finish = 1'b0;
    rd_burst_finish = 1'b0;
  endtask

  // Scoreboard monitor: every done/err pulse must match the oldest expected completion.
  always @(negedge mem_clk) begin
    if (!rst && (done_o != 3'b000 || err_o != 3'b000)) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done: done=%b err=%b", done_o, err_o);
      end else begin
        exp_t e;
        logic [2:0] oh;
        e  = exp_q.pop_front();
        oh = 3'b001 << e.port;
        check("sb_done", done_o, oh);
        check("sb_err", err_o, e.err ? oh : 3'b000);
      end
    end
  end

  initial begin
    int cnt;
    rst = 1'b1;
    req_i = '0; req_wr_i = '0; req_addr_i = '0; req_len_i = '0; req_wdata_i = '0;
    rd_burst_data_valid = 0; wr_burst_data_req = 0; rd_burst_finish = 0; wr_burst_finish = 0;
    req_wdata_i[2*DW +: DW] = WD2;
    req_wdata_i[0 +: DW]    = 128'h1111;
    repeat (3) tick();
    check("rst_gnt", gnt_o, 0);
    check("rst_done", done_o, 0);
    check("rst_req", {rd_burst_req, wr_burst_req}, 0);
    check("rst_wdata", wr_burst_data, 0);
    check("rst_beat", beat_cnt_o, 0);
    rst = 1'b0;
    tick();

    // Single read on port 0; a stray write finish must be ignored.
    set_port(0, 1'b0, 28'h40, 10'd16);
    req_i = 3'b001;
    tick();
    check("rd_req_lat", rd_burst_req, 1);
    check("rd_gnt", gnt_o, 3'b001);
    check("rd_addr", rd_burst_addr, 28'h40);
    check("rd_len", rd_burst_len, 16);
    check("rd_no_wr", wr_burst_req, 0);
    exp_q.push_back('{0, 1'b0});
    wr_burst_finish = 1'b1;
    tick();
    wr_burst_finish = 1'b0;
    check("opp_finish_ignored", rd_burst_req, 1);
    serve(0, 1'b0, 16);
    check("rd_req_drop", rd_burst_req, 0);
    check("rd_beats", beat_cnt_o, 16);
    req_i = 3'b000;
    tick();
    check("idle_gnt_clr", gnt_o, 0);

    // Round robin after reset: 0,1,2,0.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int p = 0; p < 3; p++) set_port(p, 1'b0, 28'(p * 'h100), 10'd2);
    req_i = 3'b111;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("rr_order", gnt_o, 3'b001 << (k % 3));
      exp_q.push_back('{k % 3, 1'b0});
      serve(k % 3, 1'b0, 2);
      if (k == 3) req_i = 3'b000;
      tick();
      tick();
    end

    // Port 2 write, one beat short: error with done.
    set_port(2, 1'b1, 28'h8008, 10'd16);
    req_i = 3'b100;
    tick();
    check("wr_req", wr_burst_req, 1);
    check("wr_addr", wr_burst_addr, 28'h8008);
    check("wr_data", wr_burst_data, WD2);
    exp_q.push_back('{2, 1'b1});
    serve(2, 1'b1, 15);
    check("wr_data_done", wr_burst_data, WD2);
    check("wr_beats", beat_cnt_o, 15);
    req_i = 3'b000;
    tick();

    // Port 1 read that never finishes: timeout, then port 0 granted 2 cycles later.
    set_port(1, 1'b0, 28'h200, 10'd1);
    set_port(0, 1'b0, 28'h300, 10'd4);
    req_i = 3'b010;
    tick();
    check("tmo_gnt", gnt_o, 3'b010);
    req_i = 3'b011;
    exp_q.push_back('{1, 1'b1});
    cnt = 0;
    while (rd_burst_req && cnt < 2000) begin
      cnt++;
      tick();
    end
    check("tmo_cycles", cnt, TMO);
    check("tmo_done", done_o, 3'b010);
    req_i = 3'b001;
    tick();
    check("tmo_idle", gnt_o, 0);
    tick();
    check("tmo_next_gnt", gnt_o, 3'b001);
    exp_q.push_back('{0, 1'b0});
    serve(0, 1'b0, 4);
    req_i = 3'b000;
    tick();

    // Zero-length request: done without DDR request.
    set_port(1, 1'b0, 28'h500, 10'd0);
    req_i = 3'b010;
    exp_q.push_back('{1, 1'b0});
    tick();
    check("len0_done", done_o, 3'b010);
    check("len0_noreq", {rd_burst_req, wr_burst_req}, 0);
    req_i = 3'b000;
    tick();
    check("len0_idle", gnt_o, 0);

    // Reset mid-burst aborts; port 0 wins first afterwards.
    set_port(2, 1'b1, 28'h900, 10'd8);
    req_i = 3'b100;
    tick();
    wr_burst_data_req = 1'b1; tick(); tick(); wr_burst_data_req = 1'b0;
    check("pre_rst_beats", beat_cnt_o, 2);
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", gnt_o, 0);
    check("mid_rst_req", wr_burst_req, 0);
    check("mid_rst_beat", beat_cnt_o, 0);
    check("mid_rst_addr", wr_burst_addr, 0);
    check("mid_rst_wdata", wr_burst_data, 0);
    tick();
    req_i = 3'b101;
    rst = 1'b0;
    tick();
    check("post_rst_gnt", gnt_o, 3'b001);
    exp_q.push_back('{0, 1'b0});
    serve(0, 1'b0, 4);
    req_i = 3'b000;
    repeat (3) tick();
    check("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
